// File: rtl/pps_sync_controller.sv
// Supervisory FSM between the T2-MI timestamp extractor and the PPS generator.
// Build option: define PPS_CTRL_HOLDOVER_EN to enable the HOLDOVER state.
//
// state    | meaning
// IDLE     | waiting for T2-MI stream sync
// ACQUIRE  | qualifying consecutive timestamps, PPS gated off
// LOCKED   | time loaded into generator, PPS enabled
// HOLDOVER | timestamps lost, PPS free-running for a bounded number of ticks
// FREERUN  | holdover exhausted (or disabled), PPS gated off
module pps_sync_controller #(
   parameter int unsigned LOCK_COUNT     = 3,
   parameter int unsigned TS_TIMEOUT_CYC = 200000000,
   parameter int unsigned HOLDOVER_MAX_S = 60
) (
   input  logic        clk_100mhz,
   input  logic        rst_n,
   input  logic        sync_locked,
   input  logic        ts_valid,
   input  logic [39:0] ts_seconds,
   input  logic        pps_tick,
   output logic        pps_gate,
   output logic        time_load,
   output logic [39:0] time_load_seconds,
   output logic [2:0]  state,
   output logic        holdover_active,
   output logic [15:0] holdover_seconds,
   output logic [7:0]  err_count
);

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_ACQUIRE  = 3'd1,
      ST_LOCKED   = 3'd2,
      ST_HOLDOVER = 3'd3,
      ST_FREERUN  = 3'd4
   } state_t;

   localparam int unsigned   TW       = $clog2(TS_TIMEOUT_CYC + 1);
   localparam logic [TW-1:0] TO_LIMIT = TW'(TS_TIMEOUT_CYC);
   localparam logic [3:0]    LOCK_N   = 4'(LOCK_COUNT);

   state_t        state_q;
   logic [39:0]   exp_sec_q;
   logic [3:0]    match_cnt_q;
   logic          mismatch_run_q;
   logic [TW-1:0] to_cnt_q;
   logic [7:0]    err_cnt_q;
   logic          pps_gate_q;
   logic          time_load_q;
   logic [39:0]   tls_q;

   logic [39:0]   exp_sec_d;
   logic          ts_match;
   logic          timeout;
   logic [3:0]    match_cnt_d;
   logic [7:0]    err_cnt_d;
   logic          to_active;

   // A coincident tick advances the expectation before the compare.
   assign exp_sec_d   = pps_tick ? exp_sec_q + 40'd1 : exp_sec_q;
   assign ts_match    = (ts_seconds == exp_sec_d);
   assign timeout     = (to_cnt_q == TO_LIMIT);
   assign match_cnt_d = match_cnt_q + 4'd1;
   assign err_cnt_d   = (err_cnt_q == 8'hFF) ? err_cnt_q : err_cnt_q + 8'd1;
   assign to_active   = (state_q == ST_ACQUIRE) || (state_q == ST_LOCKED);

`ifdef PPS_CTRL_HOLDOVER_EN
   localparam logic [15:0] HO_MAX = 16'(HOLDOVER_MAX_S);

   logic        ho_act_q;
   logic [15:0] ho_sec_q;
   logic [15:0] ho_sec_d;

   assign ho_sec_d = (ho_sec_q == 16'hFFFF) ? ho_sec_q : ho_sec_q + 16'd1;
`endif

   always_ff @(posedge clk_100mhz or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= ST_IDLE;
         exp_sec_q      <= '0;
         match_cnt_q    <= '0;
         mismatch_run_q <= 1'b0;
         to_cnt_q       <= '0;
         err_cnt_q      <= '0;
         pps_gate_q     <= 1'b0;
         time_load_q    <= 1'b0;
         tls_q          <= '0;
`ifdef PPS_CTRL_HOLDOVER_EN
         ho_act_q       <= 1'b0;
         ho_sec_q       <= '0;
`endif
      end else begin
         time_load_q <= 1'b0;
         exp_sec_q   <= exp_sec_d;

         if (ts_valid)
            to_cnt_q <= '0;
         else if (!to_active)
            to_cnt_q <= '0;
         else if (!timeout)
            to_cnt_q <= to_cnt_q + TW'(1);

         case (state_q)
            ST_IDLE: begin
               if (sync_locked) begin
                  state_q     <= ST_ACQUIRE;
                  match_cnt_q <= '0;
               end
            end

            ST_ACQUIRE: begin
               if (!sync_locked) begin
                  state_q <= ST_IDLE;
               end else if (timeout) begin
                  match_cnt_q <= '0;
               end else if (ts_valid) begin
                  if ((match_cnt_q == 4'd0) || !ts_match) begin
                     // Restart qualification from this timestamp.
                     exp_sec_q   <= ts_seconds;
                     match_cnt_q <= 4'd1;
                  end else begin
                     match_cnt_q <= match_cnt_d;
                     if (match_cnt_d == LOCK_N) begin
                        state_q        <= ST_LOCKED;
                        time_load_q    <= 1'b1;
                        tls_q          <= ts_seconds;
                        pps_gate_q     <= 1'b1;
                        mismatch_run_q <= 1'b0;
                     end
                  end
               end
            end

            ST_LOCKED: begin
               if (!sync_locked || timeout) begin
`ifdef PPS_CTRL_HOLDOVER_EN
                  state_q  <= ST_HOLDOVER;
                  ho_act_q <= 1'b1;
                  ho_sec_q <= '0;
`else
                  state_q    <= ST_FREERUN;
                  pps_gate_q <= 1'b0;
`endif
               end else if (ts_valid) begin
                  if (ts_match) begin
                     mismatch_run_q <= 1'b0;
                  end else begin
                     err_cnt_q <= err_cnt_d;
                     if (mismatch_run_q) begin
                        state_q        <= ST_ACQUIRE;
                        pps_gate_q     <= 1'b0;
                        match_cnt_q    <= '0;
                        mismatch_run_q <= 1'b0;
                     end else begin
                        mismatch_run_q <= 1'b1;
                     end
                  end
               end
            end

`ifdef PPS_CTRL_HOLDOVER_EN
            ST_HOLDOVER: begin
               if (sync_locked && ts_valid) begin
                  ho_act_q <= 1'b0;
                  if (ts_match) begin
                     state_q        <= ST_LOCKED;
                     ho_sec_q       <= '0;
                     mismatch_run_q <= 1'b0;
                  end else begin
                     state_q     <= ST_ACQUIRE;
                     pps_gate_q  <= 1'b0;
                     match_cnt_q <= '0;
                  end
               end else if (pps_tick) begin
                  ho_sec_q <= ho_sec_d;
                  if (ho_sec_d >= HO_MAX) begin
                     state_q    <= ST_FREERUN;
                     pps_gate_q <= 1'b0;
                     ho_act_q   <= 1'b0;
                  end
               end
            end
`endif

            ST_FREERUN: begin
               if (sync_locked) begin
                  state_q     <= ST_ACQUIRE;
                  match_cnt_q <= '0;
               end
            end

            default: begin
               state_q    <= ST_IDLE;
               pps_gate_q <= 1'b0;
            end
         endcase
      end
   end

   assign pps_gate          = pps_gate_q;
   assign time_load         = time_load_q;
   assign time_load_seconds = tls_q;
   assign state             = state_q;
   assign err_count         = err_cnt_q;

`ifdef PPS_CTRL_HOLDOVER_EN
   assign holdover_active  = ho_act_q;
   assign holdover_seconds = ho_sec_q;
`else
   assign holdover_active  = 1'b0;
   assign holdover_seconds = '0;
`endif

endmodule

// File: tb/tb_pps_sync_controller.sv
// Bench for pps_sync_controller: directed table, corner sequences and a
// randomized run against an event-level reference model.
module tb_pps_sync_controller;

   localparam int LC = 3;
   localparam int TO = 1000;
   localparam int HM = 3;
`ifdef PPS_CTRL_HOLDOVER_EN
   localparam bit HOLD = 1'b1;
`else
   localparam bit HOLD = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        sync = 1'b0;
   logic        tv = 1'b0;
   logic [39:0] ts = '0;
   logic        tick = 1'b0;
   logic        pps_gate, time_load, holdover_active;
   logic [39:0] time_load_seconds;
   logic [2:0]  state;
   logic [15:0] holdover_seconds;
   logic [7:0]  err_count;

   always #5 clk = ~clk;

   pps_sync_controller #(
      .LOCK_COUNT(LC), .TS_TIMEOUT_CYC(TO), .HOLDOVER_MAX_S(HM)
   ) dut (
      .clk_100mhz(clk), .rst_n(rst_n), .sync_locked(sync), .ts_valid(tv),
      .ts_seconds(ts), .pps_tick(tick), .pps_gate(pps_gate),
      .time_load(time_load), .time_load_seconds(time_load_seconds),
      .state(state), .holdover_active(holdover_active),
      .holdover_seconds(holdover_seconds), .err_count(err_count)
   );

   int checks = 0;
   int failures = 0;

   // Reference model: 0 idle, 1 acquire, 2 locked, 3 holdover, 4 freerun.
   int          m_state, m_cnt, m_mrun, m_tcnt, m_err, m_ho;
   logic [39:0] m_exp, m_tls;
   bit          m_gate, m_load, m_hoact;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h expected=0x%0h t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_state = 0; m_cnt = 0; m_mrun = 0; m_tcnt = 0; m_err = 0; m_ho = 0;
      m_exp = '0; m_tls = '0; m_gate = 0; m_load = 0; m_hoact = 0;
   endtask

   task automatic model_step(input bit s, input bit v, input logic [39:0] t, input bit k);
      logic [39:0] e;
      bit match, tmo;
      int ns;
      e     = k ? m_exp + 40'd1 : m_exp;
      match = v && (t == e);
      tmo   = (m_tcnt >= TO);
      m_exp = e;
      m_load = 0;
      ns = m_state;
      case (m_state)
         0: if (s) begin ns = 1; m_cnt = 0; end
         1: begin
            if (!s) ns = 0;
            else if (tmo) m_cnt = 0;
            else if (v) begin
               if (m_cnt == 0 || !match) begin m_exp = t; m_cnt = 1; end
               else begin
                  m_cnt++;
                  if (m_cnt == LC) begin m_load = 1; m_tls = t; ns = 2; m_mrun = 0; end
               end
            end
         end
         2: begin
            if (!s || tmo) begin
               if (HOLD) begin ns = 3; m_ho = 0; end else ns = 4;
            end else if (v) begin
               if (match) m_mrun = 0;
               else begin
                  if (m_err < 255) m_err++;
                  if (m_mrun > 0) begin ns = 1; m_cnt = 0; m_mrun = 0; end
                  else m_mrun = 1;
               end
            end
         end
         3: begin
            if (s && v) begin
               if (match) begin ns = 2; m_ho = 0; m_mrun = 0; end
               else begin ns = 1; m_cnt = 0; end
            end else if (k) begin
               if (m_ho < 65535) m_ho++;
               if (m_ho >= HM) ns = 4;
            end
         end
         default: if (s) begin ns = 1; m_cnt = 0; end
      endcase
      if (v) m_tcnt = 0;
      else if (m_state == 1 || m_state == 2) begin if (m_tcnt < TO) m_tcnt++; end
      else m_tcnt = 0;
      m_state = ns;
      m_gate  = (ns == 2 || ns == 3);
      m_hoact = (ns == 3);
   endtask

   task automatic check_model();
      chk("model_state", state, m_state);
      chk("model_gate", pps_gate, m_gate);
      chk("model_load", time_load, m_load);
      chk("model_tls", time_load_seconds, m_tls);
      chk("model_hoact", holdover_active, m_hoact);
      chk("model_hosec", holdover_seconds, m_ho);
      chk("model_err", err_count, m_err);
   endtask

   task automatic cycle(input bit s, input bit v, input logic [39:0] t, input bit k);
      sync = s; tv = v; ts = t; tick = k;
      @(posedge clk);
      model_step(s, v, t, k);
      #1;
      check_model();
      tv = 0; tick = 0;
   endtask

   task automatic lock_at(input logic [39:0] base);
      cycle(1, 0, '0, 0);
      cycle(1, 1, base, 0);
      cycle(1, 0, '0, 1);
      cycle(1, 1, base + 40'd1, 0);
      cycle(1, 0, '0, 1);
      cycle(1, 1, base + 40'd2, 0);
      chk("lock_state", state, 2);
      chk("lock_load", time_load, 1);
   endtask

   typedef struct {
      bit s; bit v; logic [39:0] t; bit k;
      int st; bit g; bit ld; logic [39:0] tls; int err;
   } vec_t;

   vec_t tbl[11];

   initial begin
      #5_000_000;
      $display("FAIL watchdog expired t=%0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      bit s, v, k;
      logic [39:0] t;

      tbl[0]  = '{1, 0, 40'h0,          0, 1, 0, 0, 40'h0,          0};
      tbl[1]  = '{1, 1, 40'h123456789A, 0, 1, 0, 0, 40'h0,          0};
      tbl[2]  = '{1, 0, 40'h0,          1, 1, 0, 0, 40'h0,          0};
      tbl[3]  = '{1, 1, 40'h123456789B, 0, 1, 0, 0, 40'h0,          0};
      tbl[4]  = '{1, 0, 40'h0,          1, 1, 0, 0, 40'h0,          0};
      tbl[5]  = '{1, 1, 40'h123456789C, 0, 2, 1, 1, 40'h123456789C, 0};
      tbl[6]  = '{1, 0, 40'h0,          0, 2, 1, 0, 40'h123456789C, 0};
      tbl[7]  = '{1, 1, 40'h123456789D, 1, 2, 1, 0, 40'h123456789C, 0};
      tbl[8]  = '{1, 1, 40'h55,         0, 2, 1, 0, 40'h123456789C, 1};
      tbl[9]  = '{1, 1, 40'h56,         0, 1, 0, 0, 40'h123456789C, 2};
      tbl[10] = '{1, 0, 40'h0,          0, 1, 0, 0, 40'h123456789C, 2};

      model_reset();
      repeat (3) @(posedge clk);
      #1;
      chk("rst_state", state, 0);
      chk("rst_gate", pps_gate, 0);
      chk("rst_load", time_load, 0);
      chk("rst_tls", time_load_seconds, 0);
      chk("rst_err", err_count, 0);
      chk("rst_hoact", holdover_active, 0);
      rst_n = 1;

      for (int i = 0; i < 11; i++) begin
         cycle(tbl[i].s, tbl[i].v, tbl[i].t, tbl[i].k);
         chk($sformatf("tbl%0d_state", i), state, tbl[i].st);
         chk($sformatf("tbl%0d_gate", i), pps_gate, tbl[i].g);
         chk($sformatf("tbl%0d_load", i), time_load, tbl[i].ld);
         chk($sformatf("tbl%0d_tls", i), time_load_seconds, tbl[i].tls);
         chk($sformatf("tbl%0d_err", i), err_count, tbl[i].err);
      end

      // Asynchronous reset right after a time_load pulse.
      lock_at(40'h300);
      #2 rst_n = 0;
      #1;
      chk("async_rst_gate", pps_gate, 0);
      chk("async_rst_load", time_load, 0);
      chk("async_rst_state", state, 0);
      chk("async_rst_err", err_count, 0);
      model_reset();
      @(posedge clk);
      #1 rst_n = 1;

`ifdef PPS_CTRL_HOLDOVER_EN
      lock_at(40'h100);
      cycle(0, 0, '0, 0);
      chk("ho_enter_state", state, 3);
      chk("ho_enter_act", holdover_active, 1);
      chk("ho_enter_gate", pps_gate, 1);
      for (int i = 1; i <= 3; i++) begin
         cycle(0, 0, '0, 1);
         chk($sformatf("ho_tick%0d_sec", i), holdover_seconds, i);
      end
      chk("ho_expire_state", state, 4);
      chk("ho_expire_gate", pps_gate, 0);
      chk("ho_expire_act", holdover_active, 0);
      cycle(1, 0, '0, 0);
      chk("freerun_exit_state", state, 1);

      lock_at(40'h200);
      n = 0;
      while (state != 3 && n < 1100) begin
         cycle(1, 0, '0, 0);
         n++;
      end
      chk("timeout_cycles", n, TO + 1);
      chk("timeout_state", state, 3);
      cycle(1, 1, 40'h202, 0);
      chk("recover_state", state, 2);
      chk("recover_hosec", holdover_seconds, 0);
      chk("recover_load", time_load, 0);
`else
      lock_at(40'h100);
      cycle(0, 0, '0, 0);
      chk("loss_state", state, 4);
      chk("loss_gate", pps_gate, 0);
      chk("loss_hoact", holdover_active, 0);
      cycle(1, 0, '0, 0);
      chk("freerun_exit_state", state, 1);

      lock_at(40'h200);
      n = 0;
      while (state != 4 && n < 1100) begin
         cycle(1, 0, '0, 0);
         n++;
      end
      chk("timeout_cycles", n, TO + 1);
      chk("timeout_gate", pps_gate, 0);
`endif

      for (int b = 0; b < 8; b++) begin
         int len, rate;
         len  = (b == 4) ? 1200 : 500;
         rate = (b == 4) ? 0 : ((b % 2 == 1) ? 4 : 12);
         for (int c = 0; c < len; c++) begin
            s = ($urandom_range(0, 99) < 97);
            k = ($urandom_range(0, 9) == 0);
            v = (rate > 0) && ($urandom_range(0, rate - 1) == 0);
            if ($urandom_range(0, 99) < 85) t = k ? m_exp + 40'd1 : m_exp;
            else t = {8'($urandom), 32'($urandom)};
            cycle(s, v, t, k);
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
